// File: rtl/spi_master_mode_core_if.sv
// MMIO slot bus shared by the SPI master and the software-side driver.
interface spi_master_mode_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/spi_master_mode_core.sv
// SPI master behind an MMIO slot: runtime CPOL/CPHA, bit order, SCLK divider,
// software-driven slave selects and a sticky done flag.
//
// state | meaning
// IDLE  | waiting for a start write; spi_clk parked at cpol, ready=1
// P0    | first half of a bit; miso sampled at the end of it
// P1    | second half of a bit; tx shifted (or frame closed) at the end
module spi_master_mode_core #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_master_mode_core_if.slave bus,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  output logic [NUM_SS-1:0]     spi_ss_n,
  input  logic                  spi_miso
);

  localparam int N_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, P0, P1} state_t;

  state_t            r_state;
  logic [NUM_SS-1:0] r_ss;
  logic [DIV_W-1:0]  r_dvsr;
  logic              r_cpol;
  logic              r_cpha;
  logic              r_lsb;
  logic [DIV_W-1:0]  r_dvsr_w;
  logic              r_cpol_w;
  logic              r_cpha_w;
  logic              r_lsb_w;
  logic [DIV_W-1:0]  r_cnt;
  logic [N_W-1:0]    r_n;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_done;
  logic              r_sclk;
  logic              r_mosi;

  logic              w_wr_ss;
  logic              w_wr_ctrl;
  logic              w_wr_start;
  logic              w_start;
  logic              w_cpol_nxt;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_tx_shift;
  logic [31:0]       w_rd_data;
  logic              w_unused_ok;

  assign w_wr_ss    = bus.cs && bus.write && (bus.reg_addr == 5'd1);
  assign w_wr_ctrl  = bus.cs && bus.write && (bus.reg_addr == 5'd2);
  assign w_wr_start = bus.cs && bus.write && (bus.reg_addr == 5'd3);
  assign w_start    = w_wr_start && (r_state == IDLE);

  // spi_clk is registered, so when heading into IDLE it must pick up a cpol
  // that is being written on this same edge.
  assign w_cpol_nxt = w_wr_ctrl ? bus.wr_data[16] : r_cpol;
  assign w_last_bit = (r_n == N_W'(DATA_W - 1));
  assign w_tx_shift = r_lsb_w ? (r_tx_sr >> 1) : (r_tx_sr << 1);

  // read and the unused upper write bits are intentionally ignored
  assign w_unused_ok = ^{bus.read, bus.wr_data};

  // Software-visible select and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss   <= '1;
      r_dvsr <= '0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_lsb  <= 1'b0;
    end else begin
      if (w_wr_ss) begin
        r_ss <= bus.wr_data[NUM_SS-1:0];
      end
      if (w_wr_ctrl) begin
        r_dvsr <= bus.wr_data[DIV_W-1:0];
        r_cpol <= bus.wr_data[16];
        r_cpha <= bus.wr_data[17];
        r_lsb  <= bus.wr_data[18];
      end
    end
  end

  // Frame sequencer; half-period timer is a down-counter reloaded with dvsr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dvsr_w  <= '0;
      r_cpol_w  <= 1'b0;
      r_cpha_w  <= 1'b0;
      r_lsb_w   <= 1'b0;
      r_cnt     <= '0;
      r_n       <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sclk <= w_cpol_nxt;
          if (w_start) begin
            r_dvsr_w <= r_dvsr;
            r_cpol_w <= r_cpol;
            r_cpha_w <= r_cpha;
            r_lsb_w  <= r_lsb;
            r_tx_sr  <= bus.wr_data[DATA_W-1:0];
            r_mosi   <= r_lsb ? bus.wr_data[0] : bus.wr_data[DATA_W-1];
            r_cnt    <= r_dvsr;
            r_n      <= '0;
            r_done   <= 1'b0;
            r_sclk   <= r_cpol ^ r_cpha;
            r_state  <= P0;
          end
        end
        P0: begin
          if (r_cnt == '0) begin
            r_rx_sr <= r_lsb_w ? {spi_miso, r_rx_sr[DATA_W-1:1]}
                               : {r_rx_sr[DATA_W-2:0], spi_miso};
            r_cnt   <= r_dvsr_w;
            r_sclk  <= r_cpol_w ^ ~r_cpha_w;
            r_state <= P1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        P1: begin
          if (r_cnt == '0) begin
            if (w_last_bit) begin
              r_rx_data <= r_rx_sr;
              r_done    <= 1'b1;
              r_sclk    <= w_cpol_nxt;
              r_state   <= IDLE;
            end else begin
              r_tx_sr <= w_tx_shift;
              r_mosi  <= r_lsb_w ? w_tx_shift[0] : w_tx_shift[DATA_W-1];
              r_n     <= r_n + 1'b1;
              r_cnt   <= r_dvsr_w;
              r_sclk  <= r_cpol_w ^ r_cpha_w;
              r_state <= P0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status readback ignores the address; unused bits read as zero.
  always_comb begin
    w_rd_data             = '0;
    w_rd_data[DATA_W-1:0] = r_rx_data;
    w_rd_data[DATA_W]     = (r_state == IDLE);
    w_rd_data[DATA_W+1]   = r_done;
  end

  assign bus.rd_data = w_rd_data;
  assign spi_clk     = r_sclk;
  assign spi_mosi    = r_mosi;
  assign spi_ss_n    = r_ss;

endmodule

// File: tb/tb_spi_master_mode_core.sv
// Directed bench for spi_master_mode_core with a scoreboard of expected frames.
module tb_spi_master_mode_core;

  logic       clk;
  logic       reset;
  logic       spi_clk;
  logic       spi_mosi;
  logic [3:0] spi_ss_n;
  logic       spi_miso;

  spi_master_mode_core_if bus ();

  spi_master_mode_core #(.DATA_W(8), .NUM_SS(4), .DIV_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_ss_n (spi_ss_n),
    .spi_miso (spi_miso)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic        loop_en;
  logic [7:0]  slave_tx;
  logic        slave_miso;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          fall_base;
  int          rise_base;
  logic [31:0] mosi_hist = '0;

  logic [7:0] sb_rx[$];
  logic [7:0] sb_tx[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Slave-side observers: edge counters and the bits seen on rising edges.
  always @(posedge spi_clk) begin
    rise_cnt++;
    mosi_hist = {mosi_hist[30:0], spi_mosi};
  end
  always @(negedge spi_clk) fall_cnt++;

  // MSB-first slave that presents a new bit after each falling edge.
  always_comb begin
    int idx;
    idx        = fall_cnt - fall_base;
    slave_miso = 1'b0;
    if (idx >= 1 && idx <= 8) slave_miso = slave_tx[8 - idx];
  end

  assign spi_miso = loop_en ? spi_mosi : slave_miso;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.cs       = 1'b1;
    bus.write    = 1'b1;
    bus.reg_addr = addr;
    bus.wr_data  = data;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for ready; returns the cycle stamp of the return to IDLE.
  task automatic wait_frame(input string tag, input logic [3:0] ss_exp,
                            output int t_end, output logic ss_bad);
    int budget;
    budget = 0;
    ss_bad = 1'b0;
    while (bus.rd_data[8] !== 1'b1 && budget < 1000) begin
      if (spi_ss_n !== ss_exp) ss_bad = 1'b1;
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 1000) check({tag, "_timeout"}, 32'd1, 32'd0);
    t_end = cyc;
  endtask

  task automatic check_rx(input string tag);
    if (sb_rx.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, {24'd0, bus.rd_data[7:0]}, {24'd0, sb_rx.pop_front()});
  endtask

  task automatic check_tx(input string tag);
    if (sb_tx.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, {24'd0, mosi_hist[7:0]}, {24'd0, sb_tx.pop_front()});
  endtask

  initial begin
    int   t0;
    int   t1;
    logic ss_bad;

    reset        = 1'b1;
    loop_en      = 1'b1;
    slave_tx     = 8'h00;
    fall_base    = 0;
    rise_base    = 0;
    bus.cs       = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.reg_addr = 5'd0;
    bus.wr_data  = 32'd0;
    wait_cycles(3);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(1);

    check("reset_rd_data", bus.rd_data, 32'h0000_0100);
    check("reset_ss_n", {28'd0, spi_ss_n}, 32'hF);
    check("reset_sclk", {31'd0, spi_clk}, 32'd0);
    check("reset_mosi", {31'd0, spi_mosi}, 32'd0);

    // mode 0, dvsr=1, loopback 0xA5
    wr(5'd1, 32'h0000_000E);
    wr(5'd2, 32'h0000_0001);
    rise_base = rise_cnt;
    sb_rx.push_back(8'hA5);
    wr(5'd3, 32'h0000_00A5);
    t0 = cyc;
    check("m0_busy", {31'd0, bus.rd_data[8]}, 32'd0);
    wait_frame("m0", 4'hE, t1, ss_bad);
    check("m0_frame_len", t1 - t0, 32);
    check("m0_rises", rise_cnt - rise_base, 8);
    check_rx("m0_rx");
    check("m0_ready_done", {30'd0, bus.rd_data[9:8]}, 32'd3);
    check("m0_ss_stable", {31'd0, ss_bad}, 32'd0);

    // mode 3, dvsr=3, slave returns 0x3C
    wr(5'd2, 32'h0003_0003);
    loop_en  = 1'b0;
    slave_tx = 8'h3C;
    check("m3_sclk_idle_pre", {31'd0, spi_clk}, 32'd1);
    @(negedge clk);
    fall_base = fall_cnt;
    sb_rx.push_back(8'h3C);
    sb_tx.push_back(8'h5A);
    wr(5'd3, 32'h0000_005A);
    t0 = cyc;
    wait_frame("m3", 4'hE, t1, ss_bad);
    check("m3_frame_len", t1 - t0, 64);
    check_rx("m3_rx");
    check_tx("m3_slave_cap");
    check("m3_sclk_idle_post", {31'd0, spi_clk}, 32'd1);

    // LSB-first, mode 0, loopback 0x01
    wr(5'd2, 32'h0004_0001);
    loop_en = 1'b1;
    sb_rx.push_back(8'h01);
    wr(5'd3, 32'h0000_0001);
    wait_frame("lsb", 4'hE, t1, ss_bad);
    check("lsb_first_bit", {31'd0, mosi_hist[7]}, 32'd1);
    check("lsb_rest_bits", {25'd0, mosi_hist[6:0]}, 32'd0);
    check_rx("lsb_rx");

    // start while busy is ignored
    wr(5'd2, 32'h0000_0001);
    check("busy_done_before", {31'd0, bus.rd_data[9]}, 32'd1);
    sb_rx.push_back(8'h11);
    sb_tx.push_back(8'h11);
    wr(5'd3, 32'h0000_0011);
    check("busy_done_cleared", {31'd0, bus.rd_data[9]}, 32'd0);
    wait_cycles(3);
    wr(5'd3, 32'h0000_0022);
    wait_cycles(1);
    check("busy_status_mid", {30'd0, bus.rd_data[9:8]}, 32'd0);
    wait_frame("busy", 4'hE, t1, ss_bad);
    check_rx("busy_rx");
    check_tx("busy_mosi");
    check("busy_done_after", {31'd0, bus.rd_data[9]}, 32'd1);

    // divider change mid-frame applies only to the next frame
    sb_rx.push_back(8'hC3);
    wr(5'd3, 32'h0000_00C3);
    t0 = cyc;
    wait_cycles(4);
    wr(5'd2, 32'h0000_0007);
    wait_frame("div_a", 4'hE, t1, ss_bad);
    check("div_frame_old", t1 - t0, 32);
    check_rx("div_rx_a");
    sb_rx.push_back(8'h3C);
    wr(5'd3, 32'h0000_003C);
    t0 = cyc;
    wait_frame("div_b", 4'hE, t1, ss_bad);
    check("div_frame_new", t1 - t0, 128);
    check_rx("div_rx_b");

    // async reset during bit 4 (second half, spi_clk high)
    wr(5'd2, 32'h0000_0001);
    wr(5'd3, 32'h0000_0096);
    wait_cycles(18);
    check("rst_pre_sclk", {31'd0, spi_clk}, 32'd1);
    check("rst_pre_ready", {31'd0, bus.rd_data[8]}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_ss_n", {28'd0, spi_ss_n}, 32'hF);
    check("rst_sclk", {31'd0, spi_clk}, 32'd0);
    check("rst_ready", {31'd0, bus.rd_data[8]}, 32'd1);
    check("rst_rx", {24'd0, bus.rd_data[7:0]}, 32'd0);
    check("rst_done", {31'd0, bus.rd_data[9]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
